// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, ALU ops, opcodes, mux selects.
package control_fsm_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALU_W   = 3;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned IMM_W   = 3;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned INSTR_W = 32;

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      ILLEGAL  = 4'd11
   } state_t;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SLL = 3'b011;
   localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;
   localparam logic [ALU_W-1:0] ALU_SRL = 3'b101;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b111;

   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

   localparam logic [IMM_W-1:0] IMM_I = 3'b000;
   localparam logic [IMM_W-1:0] IMM_S = 3'b001;
   localparam logic [IMM_W-1:0] IMM_B = 3'b010;
   localparam logic [IMM_W-1:0] IMM_J = 3'b011;

   // Immediate format implied by the opcode; anything unrecognised falls back to I.
   function automatic logic [IMM_W-1:0] imm_sel(input logic [OPC_W-1:0] opcode);
      case (opcode)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/control_fsm_alu_dec.sv
// Combinational ALU-op and legality decode for the supported RV32I subset.
module alu_dec
   import control_fsm_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic [F3_W-1:0]  funct3,
   input  logic             funct7b5,
   output logic [ALU_W-1:0] alu_ctrl,
   output logic             branch_neg,
   output logic             legal
);

   logic [ALU_W-1:0] arith_op;

   // funct3 to ALU op shared by register and immediate arithmetic
   always_comb begin
      arith_op = ALU_ADD;
      case (funct3)
         3'b001:  arith_op = ALU_SLL;
         3'b010:  arith_op = ALU_SLT;
         3'b100:  arith_op = ALU_XOR;
         3'b101:  arith_op = ALU_SRL;
         3'b110:  arith_op = ALU_OR;
         3'b111:  arith_op = ALU_AND;
         default: arith_op = ALU_ADD;
      endcase
   end

   always_comb begin
      alu_ctrl   = ALU_ADD;
      branch_neg = 1'b0;
      legal      = 1'b0;
      case (opcode)
         OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
         OP_RTYPE: begin
            alu_ctrl = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : arith_op;
            legal    = (funct3 != 3'b011) && (!funct7b5 || funct3 == 3'b000);
         end
         OP_ITYPE: begin
            alu_ctrl = arith_op;
            legal    = (funct3 != 3'b011) && !(funct3 == 3'b101 && funct7b5);
         end
         OP_BRANCH: begin
            case (funct3)
               3'b000: begin alu_ctrl = ALU_SUB; legal = 1'b1; end
               3'b001: begin alu_ctrl = ALU_SUB; branch_neg = 1'b1; legal = 1'b1; end
               3'b100: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
               default: legal = 1'b0;
            endcase
         end
         OP_JAL:  legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I-subset control unit: state register plus per-state datapath controls.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               branch_l,
   input  logic               mem_ready,
   output logic [ALU_W-1:0]   ALUctrl,
   output logic [SEL_W-1:0]   alu_src_a,
   output logic [SEL_W-1:0]   alu_src_b,
   output logic [SEL_W-1:0]   result_src,
   output logic [IMM_W-1:0]   imm_src,
   output logic               adr_src,
   output logic               ir_write,
   output logic               pc_write,
   output logic               mem_write,
   output logic               reg_write,
   output logic               trap,
   output logic [STATE_W-1:0] state_o
);

   state_t           state;
   state_t           next_state;
   logic [OPC_W-1:0] opcode;
   logic [ALU_W-1:0] dec_alu;
   logic             dec_neg;
   logic             dec_legal;
   logic             unused_instr;

   assign opcode       = instr[6:0];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   alu_dec u_alu_dec (
      .opcode     (opcode),
      .funct3     (instr[14:12]),
      .funct7b5   (instr[30]),
      .alu_ctrl   (dec_alu),
      .branch_neg (dec_neg),
      .legal      (dec_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= next_state;
   end

   // Reset forces every output low combinationally, so an aborted access emits nothing further.
   always_comb begin
      next_state = state;
      ALUctrl    = ALU_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      imm_src    = IMM_I;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      trap       = 1'b0;
      state_o    = '0;
      if (rst) begin
         next_state = FETCH;
      end else begin
         imm_src = imm_sel(opcode);
         state_o = state;
         case (state)
            FETCH: begin
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  next_state = DECODE;
               end
            end
            DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
               if (!dec_legal) next_state = ILLEGAL;
               else begin
                  case (opcode)
                     OP_LOAD, OP_STORE: next_state = MEMADR;
                     OP_RTYPE:          next_state = EXECR;
                     OP_ITYPE:          next_state = EXECI;
                     OP_BRANCH:         next_state = BRANCH;
                     OP_JAL:            next_state = JAL;
                     default:           next_state = ILLEGAL;
                  endcase
               end
            end
            MEMADR: begin
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_IMM;
               next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
               adr_src = 1'b1;
               if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
               result_src = RES_MEM;
               reg_write  = 1'b1;
               next_state = FETCH;
            end
            MEMWRITE: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
               if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
               ALUctrl    = dec_alu;
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_RS2;
               next_state = ALUWB;
            end
            EXECI: begin
               ALUctrl    = dec_alu;
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_IMM;
               next_state = ALUWB;
            end
            ALUWB: begin
               result_src = RES_ALUOUT;
               reg_write  = 1'b1;
               next_state = FETCH;
            end
            BRANCH: begin
               ALUctrl    = dec_alu;
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_RS2;
               result_src = RES_ALUOUT;
               pc_write   = branch_l ^ dec_neg;
               next_state = FETCH;
            end
            JAL: begin
               alu_src_a  = SRCA_OLDPC;
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALUOUT;
               pc_write   = 1'b1;
               next_state = ALUWB;
            end
            ILLEGAL: trap = 1'b1;
            default: next_state = FETCH;
         endcase
      end
   end

endmodule
